// File: rtl/firing_pkg.sv
// ----------------------------------------------------------------------------
// firing_pkg
// Shared definitions for the firing controller and the firing datapath:
//   - ctrl_e        : 3-bit command encodings on the control bus
//   - state_e       : controller FSM states
//   - MAX_SHOTS     : ammo capacity restored by a RELOAD command
//   - decode_control: maps an FSM state to the command it drives
// ----------------------------------------------------------------------------
package firing_pkg;

    typedef enum logic [2:0] {
        CTRL_RELOAD = 3'b000,
        CTRL_HOLD   = 3'b001,
        CTRL_NOP    = 3'b010,
        CTRL_SHOT   = 3'b011
    } ctrl_e;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_FIRE         = 3'd1,
        ST_SETTLE       = 3'd2,
        ST_HIT          = 3'd3,
        ST_RELOAD       = 3'd4,
        ST_CLEAR        = 3'd5,
        ST_COOLDOWN     = 3'd6,
        ST_WAIT_RELEASE = 3'd7
    } state_e;

    localparam logic [1:0] MAX_SHOTS = 2'd3;

    // HIT and CLEAR drive HOLD so the datapath drops its is_shot flag.
    function automatic ctrl_e decode_control(input state_e st);
        case (st)
            ST_FIRE:         return CTRL_SHOT;
            ST_SETTLE:       return CTRL_NOP;
            ST_RELOAD:       return CTRL_RELOAD;
            ST_IDLE,
            ST_HIT,
            ST_CLEAR,
            ST_COOLDOWN,
            ST_WAIT_RELEASE: return CTRL_HOLD;
            default:         return CTRL_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/trigger_conditioner.sv
// ----------------------------------------------------------------------------
// trigger_conditioner
// Brings the raw, asynchronous fire button into the clk domain and produces
// a one-cycle rising-edge pulse.
// Optional macro FIRING_DEBOUNCE_EN inserts a level debouncer after the
// synchronizer (DEBOUNCE_CYCLES stable cycles needed to change level).
// Ports:
//   clk     in  system clock
//   reset   in  synchronous, active-high reset
//   trigger in  raw button level
//   level   out conditioned (synced / debounced) button level
//   rise    out one-cycle pulse on a 0->1 transition of level
// All flops reset to 1 so a button held through reset never yields a rise.
// ----------------------------------------------------------------------------
module trigger_conditioner
`ifdef FIRING_DEBOUNCE_EN
#(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 16
)
`endif
(
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    output logic level,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic level_s;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= trigger;
            sync2_r <= sync1_r;
        end
    end

`ifdef FIRING_DEBOUNCE_EN
    logic             deb_r;
    logic [CNT_W-1:0] deb_cnt_r;

    // Debouncer: level follows the synced input only after it has differed
    // from the current level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_r     <= 1'b1;
            deb_cnt_r <= {CNT_W{1'b0}};
        end else if (sync2_r != deb_r) begin
            if (deb_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_r     <= sync2_r;
                deb_cnt_r <= {CNT_W{1'b0}};
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            deb_cnt_r <= {CNT_W{1'b0}};
        end
    end

    assign level_s = deb_r;
`else
    assign level_s = sync2_r;
`endif

    // Previous conditioned level for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= level_s;
        end
    end

    assign level = level_s;
    assign rise  = level_s & ~prev_r;

endmodule

// File: rtl/firing_control.sv
// ----------------------------------------------------------------------------
// firing_control
// Controller FSM for the firing datapath. Turns one accepted button press into
// exactly one SHOT command, then sequences settle, hit/reload handling, flag
// clear, a fixed cooldown and a wait for button release.
// Optional macro: FIRING_DEBOUNCE_EN (debounce the synced trigger).
// Ports:
//   clk             in  system clock
//   reset           in  synchronous, active-high reset
//   trigger         in  raw fire button (asynchronous)
//   fire_enable     in  game allows firing (checked only in IDLE)
//   is_shot         in  datapath hit flag
//   remaining_shots in  datapath ammo count
//   control         out command to datapath (see firing_pkg::ctrl_e)
//   bird_hit        out one-cycle pulse: shot hit the bird
//   out_of_ammo     out one-cycle pulse: last shot missed, reload issued
//   busy            out high whenever the FSM is not in IDLE
// Outputs are registered decodes of the next state, so they line up with the
// state register and carry no combinational path from the inputs.
// ----------------------------------------------------------------------------
module firing_control
    import firing_pkg::*;
#(
    parameter int unsigned COOLDOWN_CYCLES = 16,
    parameter int unsigned CNT_W           = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 8
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       trigger,
    input  logic       fire_enable,
    input  logic       is_shot,
    input  logic [1:0] remaining_shots,
    output logic [2:0] control,
    output logic       bird_hit,
    output logic       out_of_ammo,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CD_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

    // Elaboration-time guard on the parameter set.
    if ((COOLDOWN_CYCLES < 1) || (DEBOUNCE_CYCLES < 1) ||
        (64'(COOLDOWN_CYCLES) > (64'd1 << CNT_W)) ||
        (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_W))) begin : g_bad_params
        $error("firing_control: COOLDOWN_CYCLES/DEBOUNCE_CYCLES must be >=1 and fit CNT_W");
    end

    state_e           state_r;
    state_e           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    ctrl_e            control_r;
    logic             bird_hit_r;
    logic             out_of_ammo_r;
    logic             busy_r;
    logic             trig_level_s;
    logic             trig_rise_s;

    trigger_conditioner
`ifdef FIRING_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    )
`endif
    u_trigger_conditioner (
        .clk     (clk),
        .reset   (reset),
        .trigger (trigger),
        .level   (trig_level_s),
        .rise    (trig_rise_s)
    );

    // Next-state and cooldown-counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                // A rise that is not accepted here is simply dropped.
                if (trig_rise_s && fire_enable && (remaining_shots != 2'd0)) begin
                    state_next_s = ST_FIRE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                state_next_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Hit wins over ammo exhaustion: a hit on the last shot
                // reports the hit and does not reload.
                if (is_shot) begin
                    state_next_s = ST_HIT;
                end else if (remaining_shots == 2'd0) begin
                    state_next_s = ST_RELOAD;
                end else begin
                    state_next_s = ST_COOLDOWN;
                    cnt_next_s   = CD_LOAD;
                end
            end
            ST_HIT: begin
                state_next_s = ST_COOLDOWN;
                cnt_next_s   = CD_LOAD;
            end
            ST_RELOAD: begin
                state_next_s = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_next_s = ST_COOLDOWN;
                cnt_next_s   = CD_LOAD;
            end
            ST_COOLDOWN: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_WAIT_RELEASE;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_RELEASE: begin
                // Requiring release prevents a held button from auto-repeating.
                if (!trig_level_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_WAIT_RELEASE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and registered output decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            control_r     <= CTRL_HOLD;
            bird_hit_r    <= 1'b0;
            out_of_ammo_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            control_r     <= decode_control(state_next_s);
            bird_hit_r    <= (state_next_s == ST_HIT);
            out_of_ammo_r <= (state_next_s == ST_RELOAD);
            busy_r        <= (state_next_s != ST_IDLE);
        end
    end

    assign control     = control_r;
    assign bird_hit    = bird_hit_r;
    assign out_of_ammo = out_of_ammo_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_firing_control.sv
// ----------------------------------------------------------------------------
// tb_firing_control
// Directed bench for firing_control (default parameters, debounce disabled).
// Expected values are hand-derived: press before edge N -> SHOT visible after
// edge N+2, NOP next cycle, 16 HOLD cooldown cycles, one WAIT_RELEASE cycle,
// then IDLE. The bench plays the datapath by driving is_shot/remaining_shots.
// ----------------------------------------------------------------------------
module tb_firing_control;

    localparam logic [2:0] C_RELOAD = 3'b000;
    localparam logic [2:0] C_HOLD   = 3'b001;
    localparam logic [2:0] C_NOP    = 3'b010;
    localparam logic [2:0] C_SHOT   = 3'b011;

    logic       clk = 1'b0;
    logic       reset;
    logic       trigger;
    logic       fire_enable;
    logic       is_shot;
    logic [1:0] remaining_shots;
    logic [2:0] control;
    logic       bird_hit;
    logic       out_of_ammo;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int shots    = 0;

    always #5 clk = ~clk;

    firing_control dut (
        .clk             (clk),
        .reset           (reset),
        .trigger         (trigger),
        .fire_enable     (fire_enable),
        .is_shot         (is_shot),
        .remaining_shots (remaining_shots),
        .control         (control),
        .bird_hit        (bird_hit),
        .out_of_ammo     (out_of_ammo),
        .busy            (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compares {control, busy, bird_hit, out_of_ammo} in one go.
    task automatic expect_out(input string tag, input logic [2:0] c,
                              input logic b, input logic h, input logic o);
        check(tag, {26'd0, control, busy, bird_hit, out_of_ammo}, {26'd0, c, b, h, o});
    endtask

    // One-cycle press from IDLE, checked through SETTLE (NOP visible at exit).
    task automatic press_to_settle(input string tag);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        expect_out({tag, "_e1"}, C_HOLD, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out({tag, "_e2"}, C_HOLD, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out({tag, "_shot"}, C_SHOT, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out({tag, "_settle"}, C_NOP, 1'b1, 1'b0, 1'b0);
    endtask

    // From the state just before COOLDOWN: 16 cooldown, 1 wait-release, idle.
    task automatic cooldown_to_idle(input string tag);
        for (int i = 0; i < 16; i++) begin
            tick();
            expect_out({tag, "_cool"}, C_HOLD, 1'b1, 1'b0, 1'b0);
        end
        tick();
        expect_out({tag, "_wrel"}, C_HOLD, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out({tag, "_idle"}, C_HOLD, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset           = 1'b1;
        trigger         = 1'b0;
        fire_enable     = 1'b1;
        is_shot         = 1'b0;
        remaining_shots = 2'd3;
        tick();
        tick();
        expect_out("reset", C_HOLD, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        expect_out("idle0", C_HOLD, 1'b0, 1'b0, 1'b0);

        // Single miss with ammo left.
        press_to_settle("miss");
        remaining_shots = 2'd2;
        cooldown_to_idle("miss");

        // Hit on the last shot: bird_hit only, no reload.
        press_to_settle("hit");
        is_shot         = 1'b1;
        remaining_shots = 2'd0;
        tick();
        expect_out("hit_pulse", C_HOLD, 1'b1, 1'b1, 1'b0);
        is_shot = 1'b0;
        cooldown_to_idle("hit");

        // Three misses 3->2->1->0, then reload.
        remaining_shots = 2'd3;
        press_to_settle("m1");
        remaining_shots = 2'd2;
        cooldown_to_idle("m1");
        press_to_settle("m2");
        remaining_shots = 2'd1;
        cooldown_to_idle("m2");
        press_to_settle("m3");
        remaining_shots = 2'd0;
        tick();
        expect_out("reload", C_RELOAD, 1'b1, 1'b0, 1'b1);
        remaining_shots = 2'd3;
        is_shot         = 1'b1;
        tick();
        expect_out("clear", C_HOLD, 1'b1, 1'b0, 1'b0);
        is_shot = 1'b0;
        cooldown_to_idle("reload");

        // Trigger held for 100 cycles: exactly one SHOT, stuck in WAIT_RELEASE.
        shots   = 0;
        trigger = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (control === C_SHOT) shots++;
        end
        check("held_shots", 32'(shots), 32'd1);
        expect_out("held_wrel", C_HOLD, 1'b1, 1'b0, 1'b0);
        trigger = 1'b0;
        tick();
        tick();
        expect_out("held_still_wrel", C_HOLD, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("held_idle", C_HOLD, 1'b0, 1'b0, 1'b0);

        // Repeated presses during the sequence are ignored.
        shots   = 0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        tick();
        expect_out("rep_shot", C_SHOT, 1'b1, 1'b0, 1'b0);
        shots = 1;
        for (int i = 0; i < 12; i++) begin
            trigger = (i % 3 == 0);
            tick();
            if (control === C_SHOT) shots++;
        end
        trigger = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (control === C_SHOT) shots++;
        end
        check("rep_shots", 32'(shots), 32'd1);
        expect_out("rep_idle", C_HOLD, 1'b0, 1'b0, 1'b0);

        // fire_enable low in IDLE blocks a press.
        fire_enable = 1'b0;
        trigger     = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("fe_block", C_HOLD, 1'b0, 1'b0, 1'b0);
        end
        fire_enable = 1'b1;

        // No ammo in IDLE blocks a press.
        remaining_shots = 2'd0;
        trigger         = 1'b1;
        tick();
        trigger = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out("ammo_block", C_HOLD, 1'b0, 1'b0, 1'b0);
        end
        remaining_shots = 2'd3;

        // fire_enable dropped mid-sequence does not abort it.
        press_to_settle("fe_mid");
        fire_enable = 1'b0;
        cooldown_to_idle("fe_mid");
        fire_enable = 1'b1;

        // Reset during cooldown with trigger held: no SHOT until release+press.
        trigger = 1'b1;
        tick();
        tick();
        tick();
        expect_out("rst_shot", C_SHOT, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        expect_out("rst_cool", C_HOLD, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        expect_out("rst_mid", C_HOLD, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out("rst_held", C_HOLD, 1'b0, 1'b0, 1'b0);
        end
        trigger = 1'b0;
        tick();
        tick();
        tick();
        press_to_settle("after_rst");
        cooldown_to_idle("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
